// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequencing FSM for an iterative DES datapath.
// Ports: clk/n_rst; in_valid/in_ready/decrypt request handshake;
//   ip_load, round_en, round_idx, key_shift_amt, key_shift_right,
//   fp_load datapath strobes; out_valid/out_ready result handshake;
//   busy when not idle.
module des_round_ctrl #(
    parameter int ROUNDS = 16
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          decrypt,
    output logic          ip_load,
    output logic          round_en,
    output logic [((ROUNDS > 1) ? $clog2(ROUNDS) : 1)-1:0] round_idx,
    output logic [1:0]    key_shift_amt,
    output logic          key_shift_right,
    output logic          fp_load,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    localparam int IW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] cnt;
    logic [IW-1:0] cnt_nxt;
    logic          mode_q;
    logic          mode_nxt;

    // Per-round C/D rotation. Decrypt round 0 uses no rotation because
    // the encrypt rotations sum to 28, leaving C/D at K16's position.
    function automatic logic [1:0] shift_for(
        input logic [IW-1:0] idx,
        input logic          dec
    );
        logic [1:0] amt;
        case (int'(idx))
            0:         amt = dec ? 2'd0 : 2'd1;
            1, 8, 15:  amt = 2'd1;
            default:   amt = 2'd2;
        endcase
        return amt;
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                    mode_nxt  = decrypt;
                end
            end
            LOAD: begin
                state_nxt = ROUND;
            end
            ROUND: begin
                if (cnt == LAST) begin
                    state_nxt = FINAL;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            FINAL: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready        = 1'b0;
        busy            = 1'b1;
        ip_load         = 1'b0;
        round_en        = 1'b0;
        round_idx       = '0;
        key_shift_amt   = 2'd0;
        key_shift_right = 1'b0;
        fp_load         = 1'b0;
        out_valid       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            LOAD: begin
                ip_load = 1'b1;
            end
            ROUND: begin
                round_en        = 1'b1;
                round_idx       = cnt;
                key_shift_amt   = shift_for(cnt, mode_q);
                key_shift_right = mode_q;
            end
            FINAL: begin
                fp_load = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_des_round_ctrl.sv
// tb_des_round_ctrl: randomized self-checking bench for des_round_ctrl.
// Expected outputs come from the cycle offset since the accept edge.
module tb_des_round_ctrl;

    localparam int R  = 16;
    localparam int IW = $clog2(R);

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          decrypt = 1'b0;
    logic          ip_load;
    logic          round_en;
    logic [IW-1:0] round_idx;
    logic [1:0]    key_shift_amt;
    logic          key_shift_right;
    logic          fp_load;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;

    des_round_ctrl #(.ROUNDS(R)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .decrypt         (decrypt),
        .ip_load         (ip_load),
        .round_en        (round_en),
        .round_idx       (round_idx),
        .key_shift_amt   (key_shift_amt),
        .key_shift_right (key_shift_right),
        .fp_load         (fp_load),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int enc_sh [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int dec_sh [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // Reference: a block is in flight, k cycles after its accept edge.
    bit m_active = 0;
    int m_k = 0;
    bit m_mode = 0;
    int ip_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     tag, cyc, obs, exp);
        end
    endtask

    function automatic bit e_ov();
        return m_active && m_k >= R + 3;
    endfunction

    function automatic bit e_ren();
        return m_active && m_k >= 2 && m_k <= R + 1;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_k = 0;
        m_mode = 0;
    endtask

    task automatic model_edge();
        if (!n_rst) begin
            model_reset();
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1;
                m_k = 1;
                m_mode = decrypt;
            end
        end else if (e_ov() && out_ready) begin
            m_active = 0;
        end else begin
            m_k++;
        end
    endtask

    task automatic compare_all();
        int ei;
        int ea;
        ei = e_ren() ? m_k - 2 : 0;
        ea = e_ren() ? (m_mode ? dec_sh[ei] : enc_sh[ei]) : 0;
        chk("in_ready", in_ready, !m_active);
        chk("busy", busy, m_active);
        chk("ip_load", ip_load, m_active && m_k == 1);
        chk("round_en", round_en, e_ren());
        chk("round_idx", round_idx, ei);
        chk("shift_amt", key_shift_amt, ea);
        if (e_ren() || !n_rst)
            chk("shift_right", key_shift_right, e_ren() && m_mode);
        chk("fp_load", fp_load, m_active && m_k == R + 2);
        chk("out_valid", out_valid, e_ov());
        if (ip_load) ip_seen++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic accept(input bit dec);
        in_valid = 1;
        decrypt = dec;
        step();
        in_valid = 0;
    endtask

    // Async reset asserted mid-cycle; outputs must react before any edge.
    task automatic pulse_reset();
        n_rst = 0;
        #1;
        model_reset();
        compare_all();
        step();
        n_rst = 1;
    endtask

    initial begin
        bit found;
        int ip_before;

        // Reset held for 3 cycles, then idle.
        run(3);
        n_rst = 1;
        run(10);

        // Encrypt, out_ready tied high.
        out_ready = 1;
        accept(0);
        run(R + 6);

        // Decrypt.
        accept(1);
        run(R + 6);

        // Backpressure with a pending request.
        out_ready = 0;
        accept(0);
        in_valid = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = out_valid;
        end
        chk("bp_wait", found, 1);
        ip_before = ip_seen;
        run(7);
        chk("bp_no_ip", ip_seen, ip_before);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1;
        step();
        chk("bp_idle", in_ready, 1);
        step();
        chk("bp_pending", ip_load, 1);
        in_valid = 0;
        run(R + 6);

        // Mode stability: decrypt toggles while running.
        accept(0);
        for (int i = 0; i < R + 5; i++) begin
            decrypt = ~decrypt;
            step();
        end

        // Reset during round 7, then a fresh request.
        accept(1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = round_en && round_idx == 7;
        end
        chk("rst_wait", found, 1);
        pulse_reset();
        chk("rst_ren", round_en, 0);
        chk("rst_ready", in_ready, 1);
        run(25);
        accept(0);
        run(R + 6);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            decrypt   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 199) == 0)
                pulse_reset();
            else
                step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
